// File: rtl/float_pkg.sv
// Shared float constants and lane sizing helpers.
// Imported by the fan-out top, its lane FIFOs and the bench.
package float_pkg;
  localparam int FLOAT_SIZE = 32;
  localparam logic [31:0] FLOAT_ONE = 32'h3F800000;
  localparam int LANE_DEPTH = 4;

  function automatic int clog2_p1(input int d);
    return $clog2(d + 1);
  endfunction

  typedef logic [clog2_p1(LANE_DEPTH)-1:0] lane_count_t;
endpackage

// File: rtl/float_lane_fifo.sv
// One output lane: DEPTH-entry synchronous FIFO.
// Push side has no ready; the caller gates push with !full.
module float_lane_fifo
  import float_pkg::*;
#(
  parameter int SIZE  = FLOAT_SIZE,
  parameter int DEPTH = LANE_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [SIZE-1:0]              push_data,
  output logic [SIZE-1:0]              m_tdata,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = clog2_p1(DEPTH);

  logic [SIZE-1:0] mem_q [DEPTH];
  logic [SIZE-1:0] mem_d [DEPTH];
  logic [PW-1:0]   wr_q, wr_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pop;

  assign pop = (cnt_q != '0) && m_tready;

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = push_data;
    wr_d = wr_q + PW'(push);
    rd_d = rd_q + PW'(pop);
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign m_tdata  = mem_q[rd_q];
  assign m_tvalid = (cnt_q != '0);
  assign full     = (cnt_q == CW'(DEPTH));
  assign count    = cnt_q;
endmodule

// File: rtl/float_fanout3.sv
// Fans one float stream out to three independently drained lanes.
// Input stalls only when some lane FIFO is full.
module float_fanout3
  import float_pkg::*;
#(
  parameter int SIZE  = FLOAT_SIZE,
  parameter int DEPTH = LANE_DEPTH
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [SIZE-1:0]                s_axis_tdata,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  output logic [SIZE-1:0]                m_axis_a_tdata,
  output logic                           m_axis_a_tvalid,
  input  logic                           m_axis_a_tready,
  output logic [SIZE-1:0]                m_axis_b_tdata,
  output logic                           m_axis_b_tvalid,
  input  logic                           m_axis_b_tready,
  output logic [SIZE-1:0]                m_axis_c_tdata,
  output logic                           m_axis_c_tvalid,
  input  logic                           m_axis_c_tready,
  output logic [3*$clog2(DEPTH+1)-1:0]   lane_level
);
  localparam int CW = clog2_p1(DEPTH);

  logic          full_a, full_b, full_c;
  logic [CW-1:0] cnt_a, cnt_b, cnt_c;
  logic          push;

  assign s_axis_tready = !areset && !full_a && !full_b && !full_c;
  assign push          = s_axis_tvalid && s_axis_tready;
  assign lane_level    = {cnt_c, cnt_b, cnt_a};

  float_lane_fifo #(.SIZE(SIZE), .DEPTH(DEPTH)) u_lane_a (
    .clk(aclk), .rst(areset),
    .push(push), .push_data(s_axis_tdata),
    .m_tdata(m_axis_a_tdata), .m_tvalid(m_axis_a_tvalid),
    .m_tready(m_axis_a_tready),
    .full(full_a), .count(cnt_a)
  );

  float_lane_fifo #(.SIZE(SIZE), .DEPTH(DEPTH)) u_lane_b (
    .clk(aclk), .rst(areset),
    .push(push), .push_data(s_axis_tdata),
    .m_tdata(m_axis_b_tdata), .m_tvalid(m_axis_b_tvalid),
    .m_tready(m_axis_b_tready),
    .full(full_b), .count(cnt_b)
  );

  float_lane_fifo #(.SIZE(SIZE), .DEPTH(DEPTH)) u_lane_c (
    .clk(aclk), .rst(areset),
    .push(push), .push_data(s_axis_tdata),
    .m_tdata(m_axis_c_tdata), .m_tvalid(m_axis_c_tvalid),
    .m_tready(m_axis_c_tready),
    .full(full_c), .count(cnt_c)
  );
endmodule

// File: tb/tb_float_fanout3.sv
// Bench for float_fanout3: per-lane queue model, directed and random steps.
// Outputs are checked on the falling edge; inputs change just after rising.
module tb_float_fanout3;
  import float_pkg::*;

  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic              aclk = 1'b0;
  logic              areset;
  logic [31:0]       s_tdata;
  logic              s_tvalid;
  logic              s_tready;
  logic [31:0]       a_tdata, b_tdata, c_tdata;
  logic              a_tvalid, b_tvalid, c_tvalid;
  logic              a_tready, b_tready, c_tready;
  logic [3*CW-1:0]   lane_level;

  logic [31:0] qa[$], qb[$], qc[$], pending[$];
  logic        last_acc;
  int          checks = 0;
  int          errors = 0;

  always #5 aclk = ~aclk;

  float_fanout3 #(.SIZE(32), .DEPTH(D)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .m_axis_a_tdata(a_tdata), .m_axis_a_tvalid(a_tvalid),
    .m_axis_a_tready(a_tready),
    .m_axis_b_tdata(b_tdata), .m_axis_b_tvalid(b_tvalid),
    .m_axis_b_tready(b_tready),
    .m_axis_c_tdata(c_tdata), .m_axis_c_tvalid(c_tvalid),
    .m_axis_c_tready(c_tready),
    .lane_level(lane_level)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_lane(input string n, input logic v,
                          input logic [31:0] d, input logic [CW-1:0] lvl,
                          input int sz, input logic [31:0] head);
    chk({n, "_tvalid"}, 32'(v), 32'(sz != 0));
    chk({n, "_level"}, 32'(lvl), 32'(sz));
    if (sz != 0) chk({n, "_tdata"}, d, head);
  endtask

  // One clock of the model: check at negedge, update at posedge.
  task automatic cycle();
    logic rdy, pa, pb, pc, acc;
    logic [31:0] w;
    @(negedge aclk);
    rdy = (qa.size() < D) && (qb.size() < D) && (qc.size() < D);
    chk("s_tready", 32'(s_tready), 32'(rdy));
    chk_lane("a", a_tvalid, a_tdata, lane_level[0 +: CW],
             qa.size(), qa.size() ? qa[0] : 32'h0);
    chk_lane("b", b_tvalid, b_tdata, lane_level[CW +: CW],
             qb.size(), qb.size() ? qb[0] : 32'h0);
    chk_lane("c", c_tvalid, c_tdata, lane_level[2*CW +: CW],
             qc.size(), qc.size() ? qc[0] : 32'h0);
    pa  = (qa.size() != 0) && a_tready;
    pb  = (qb.size() != 0) && b_tready;
    pc  = (qc.size() != 0) && c_tready;
    acc = s_tvalid && rdy;
    w   = s_tdata;
    @(posedge aclk);
    if (pa) void'(qa.pop_front());
    if (pb) void'(qb.pop_front());
    if (pc) void'(qc.pop_front());
    if (acc) begin
      qa.push_back(w);
      qb.push_back(w);
      qc.push_back(w);
    end
    last_acc = acc;
    #1;
  endtask

  task automatic feed(input int ncyc, input bit rnd);
    for (int i = 0; i < ncyc && pending.size() != 0; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = pending[0];
      if (rnd) begin
        a_tready = 1'($urandom_range(0, 1));
        b_tready = 1'($urandom_range(0, 1));
        c_tready = 1'($urandom_range(0, 1));
      end
      cycle();
      if (last_acc) void'(pending.pop_front());
    end
    s_tvalid = 1'b0;
    s_tdata  = 32'h0;
  endtask

  task automatic send(input string tag, input int budget, input bit rnd);
    feed(budget, rnd);
    checks++;
    assert (pending.size() == 0) else begin
      errors++;
      $error("FAIL %s_timeout observed %0d left expected 0",
             tag, pending.size());
      pending.delete();
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    a_tready = 1'b1;
    b_tready = 1'b1;
    c_tready = 1'b1;
    while ((qa.size() + qb.size() + qc.size()) != 0 && n < budget) begin
      cycle();
      n++;
    end
    cycle();
    checks++;
    assert (n < budget) else begin
      errors++;
      $error("FAIL %s_drain observed %0d cycles expected < %0d",
             tag, n, budget);
    end
  endtask

  initial begin
    areset   = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = 32'h0;
    a_tready = 1'b0;
    b_tready = 1'b0;
    c_tready = 1'b0;
    last_acc = 1'b0;
    #12;
    chk("rst_tready", 32'(s_tready), 32'h0);
    chk("rst_valid", 32'({a_tvalid, b_tvalid, c_tvalid}), 32'h0);
    chk("rst_level", 32'(lane_level), 32'h0);
    chk("rst_a_data", a_tdata, 32'h0);
    chk("rst_c_data", c_tdata, 32'h0);
    @(posedge aclk);
    #1 areset = 1'b0;

    // Free flow
    a_tready = 1'b1;
    b_tready = 1'b1;
    c_tready = 1'b1;
    pending = '{FLOAT_ONE, 32'h40000000, 32'h40400000};
    send("t1", 10, 1'b0);
    drain("t1", 10);

    // Single slow lane b
    b_tready = 1'b0;
    for (int i = 1; i <= 6; i++) pending.push_back(32'h41000000 + 32'(i));
    feed(8, 1'b0);
    chk("t2_b_level", 32'(lane_level[CW +: CW]), 32'd4);
    chk("t2_stall", 32'(s_tready), 32'h0);
    chk("t2_left", 32'(pending.size()), 32'd2);
    b_tready = 1'b1;
    send("t2", 20, 1'b0);
    drain("t2", 20);

    // Push attempt while lane c is full and popping
    c_tready = 1'b0;
    for (int i = 0; i < 4; i++) pending.push_back(32'h42000000 + 32'(i));
    send("t3fill", 10, 1'b0);
    chk("t3_c_level4", 32'(lane_level[2*CW +: CW]), 32'd4);
    chk("t3_tready0", 32'(s_tready), 32'h0);
    c_tready = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = 32'h42AA0000;
    cycle();
    chk("t3_pop_only", 32'(last_acc), 32'h0);
    chk("t3_c_level3a", 32'(lane_level[2*CW +: CW]), 32'd3);
    cycle();
    chk("t3_accept", 32'(last_acc), 32'h1);
    chk("t3_c_level3b", 32'(lane_level[2*CW +: CW]), 32'd3);
    s_tvalid = 1'b0;
    drain("t3", 20);

    // Wrap-around with random lane back-pressure
    for (int i = 0; i < 3*D+1; i++) pending.push_back($urandom);
    send("t4", 400, 1'b1);
    drain("t4", 30);

    // Reset with two beats buffered everywhere
    a_tready = 1'b0;
    b_tready = 1'b0;
    c_tready = 1'b0;
    pending = '{32'h43000001, 32'h43000002};
    send("t5fill", 5, 1'b0);
    areset = 1'b1;
    #1;
    chk("t5_valid", 32'({a_tvalid, b_tvalid, c_tvalid}), 32'h0);
    chk("t5_level", 32'(lane_level), 32'h0);
    chk("t5_tready", 32'(s_tready), 32'h0);
    qa.delete();
    qb.delete();
    qc.delete();
    @(posedge aclk);
    #1 areset = 1'b0;
    a_tready = 1'b1;
    b_tready = 1'b1;
    c_tready = 1'b1;
    pending = '{32'hC0A00000};
    send("t5", 5, 1'b0);
    chk("t5_first_a", a_tdata, 32'hC0A00000);
    chk("t5_first_c", c_tdata, 32'hC0A00000);
    drain("t5", 10);

    // Input bubbles with changing data while tvalid is low
    a_tready = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = 32'h44000001;
    cycle();
    s_tvalid = 1'b0;
    s_tdata  = $urandom;
    cycle();
    s_tdata  = $urandom;
    cycle();
    s_tvalid = 1'b1;
    s_tdata  = 32'h44000002;
    cycle();
    s_tvalid = 1'b0;
    chk("t6_a_level", 32'(lane_level[0 +: CW]), 32'd2);
    drain("t6", 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/float_fanout3.md
Name: float_fanout3

Overview:
- Splits one AXI-Stream float result stream into three independent consumer streams (a, b, c). Every input beat is delivered once, in order, to each output.
- This is the fan-out counterpart of the three-input float summation join. It feeds one intermediate float result to several downstream float_add / float_mult instances.
- Each output has its own small FIFO, so one slow consumer does not stall the others until its FIFO fills.

Parameters:
- SIZE, 32, width of the float word in bits.
- DEPTH, 4, entries per output lane FIFO. Must be a power of two and at least 2.

Ports:
- aclk  in  1  clock; all logic is rising-edge.
- areset  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  SIZE  input float word.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat accepted when high together with s_axis_tvalid.
- m_axis_a_tdata  out  SIZE  lane a data.
- m_axis_a_tvalid  out  1  lane a valid.
- m_axis_a_tready  in  1  lane a consumer ready.
- m_axis_b_tdata / m_axis_b_tvalid / m_axis_b_tready: same as lane a, for lane b.
- m_axis_c_tdata / m_axis_c_tvalid / m_axis_c_tready: same as lane a, for lane c.
- lane_level  out  3*$clog2(DEPTH+1)  per-lane occupancy. Lane a is in the least-significant slice.

Behaviour:
- Reset (async assert, sync release):
  - All lane pointers and counts clear to 0.
  - All m_axis_*_tvalid = 0.
  - lane_level = 0.
  - m_axis_*_tdata = 0.
  - s_axis_tready = 0 while areset is high.
  - Reset mid-operation discards all buffered beats; no partial delivery after release.
- Input acceptance:
  - s_axis_tready = !areset && !full_a && !full_b && !full_c.
  - There is no read-through when full. tready depends only on registered full flags, never on m_axis_*_tready.
- Write:
  - On the s_axis_tvalid && s_axis_tready edge, the word is written into all three lanes in the same cycle.
  - Every lane count increments unless that lane also pops in the same cycle.
- Latency:
  - A beat accepted at edge N appears on every empty lane's m_axis output, with tvalid high, after edge N (first cycle N+1).
  - There is no combinational path from input to output.
- Lane output:
  - tvalid = (count != 0); tdata = head entry.
  - Pop on tvalid && tready.
  - Simultaneous push and pop in the same lane leaves the count unchanged; head and tail both advance.
- Lane independence:
  - Lanes drain independently. Lane a may be up to DEPTH beats ahead of lane c.
  - Input stalls only when some lane is full.
- AXI rules:
  - Once m_axis_x_tvalid is high, tvalid and tdata stay stable until that lane's handshake.
  - Input-side back-pressure is tolerated: tdata is sampled only on handshake.
- Pointers:
  - $clog2(DEPTH)-bit read/write pointers, wrapping naturally modulo DEPTH.
  - count width is $clog2(DEPTH+1).
  - full = (count == DEPTH); empty = (count == 0).
- Ordering: each lane emits beats in exactly the order they were accepted. There is no reordering or duplication within a lane.

Decomposition:
- float_pkg holds:
  - FLOAT_SIZE = 32
  - the FLOAT_ONE constant 32'h3F800000, used by the bench
  - a lane_count_t typedef sized from DEPTH via function clog2_p1.
- Sub-module: float_lane_fifo.
  - Contains one DEPTH-entry synchronous FIFO with AXI-Stream push/pop, plus full and count outputs.
  - It is instantiated three times.
  - The top level holds only the tready AND-reduction and the level concatenation.

Test Plan:
1. Free flow: all m tready = 1; send 0x3F800000, 0x40000000, 0x40400000 back-to-back → each lane outputs the same three words in order, the first one cycle after acceptance; s_axis_tready stays 1 throughout.
2. Single slow lane: m_axis_b_tready = 0, others 1; send 6 beats → lane_level for b reaches 4; s_axis_tready drops after beat 4 is accepted; lanes a and c deliver beats 1-4. Then raise b tready → b drains beats 1-4 in order and input resumes with beats 5-6.
3. Push and pop at full: lane c full (level 4) with c tready = 1 and s_axis_tvalid = 1 → that cycle is a pop only (tready = 0); the next cycle accepts the new beat; level goes 4→3→3.
4. Wrap-around: 3*DEPTH+1 beats with random per-lane tready → every lane outputs the exact 13-word sequence; no loss or duplication.
5. Reset mid-stream: assert areset with 2 beats buffered in every lane → tvalid of all lanes drops immediately (asynchronously) and lane_level = 0. After release, the first new beat 0xC0A00000 is the first word on all lanes.
6. Input bubbles: s_axis_tvalid toggling 1,0,1 with changing tdata while tvalid is low → only the two handshaked words appear at each lane.
